systolic_host_loader: RTL and testbench

- Host-side initiator for the 4x4 systolic matrix controller.
- Accepts a valid/ready word stream and writes it into data memory A, then data memory B, through the controller's write ports.
- Drives the controller enable until the controller reports completion, then reads back result memory C and returns it as a valid/ready output stream.
- Sits between the host bus adapter and the controller.

---
 rtl/systolic_host_loader.sv | 195 +++++++++++++++++++
 tb/tb_systolic_host_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_host_loader.sv
// Host-side initiator for the 4x4 systolic matrix controller: streams operands into
// memories A and B, runs the controller, then drains result memory C as a stream.
module systolic_host_loader #(
  parameter int unsigned N_WORDS     = 16,
  parameter int unsigned N_RESULTS   = 16,
  parameter int unsigned C_RD_LAT    = 1,
  parameter int unsigned RUN_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        w_en_A,
  output logic [6:0]  write_addr_A,
  output logic [15:0] write_data_A,
  output logic        w_en_B,
  output logic [6:0]  write_addr_B,
  output logic [15:0] write_data_B,
  output logic        en,
  input  logic        done,
  output logic [4:0]  read_addr_C,
  input  logic [15:0] read_data_C,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        timeout
);

  localparam int unsigned AW = 7;
  localparam int unsigned CW = 5;
  localparam int unsigned LW = 2;
  localparam int unsigned TW = $clog2(RUN_TIMEOUT + 1);

  localparam logic [AW-1:0] WORD_LAST = AW'(N_WORDS - 1);
  localparam logic [CW-1:0] RES_LAST  = CW'(N_RESULTS - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(C_RD_LAT - 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(RUN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_ARM,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [CW-1:0]   idx;
  logic [LW-1:0]   lat_cnt;
  logic [TW-1:0]   tmr;
  logic            rd_pend;
  logic            hs;

  assign hs = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      lat_cnt      <= '0;
      tmr          <= '0;
      rd_pend      <= 1'b0;
      busy         <= 1'b0;
      in_ready     <= 1'b0;
      w_en_A       <= 1'b0;
      write_addr_A <= '0;
      write_data_A <= '0;
      w_en_B       <= 1'b0;
      write_addr_B <= '0;
      write_data_B <= '0;
      en           <= 1'b0;
      read_addr_C  <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      w_en_A <= 1'b0;
      w_en_B <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD_A;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            cnt      <= '0;
            timeout  <= 1'b0;
          end
        end

        S_LOAD_A: begin
          if (hs) begin
            w_en_A       <= 1'b1;
            write_addr_A <= cnt;
            write_data_A <= in_data;
            if (cnt == WORD_LAST) begin
              cnt   <= '0;
              state <= S_LOAD_B;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end

        // Last B word closes the input port and starts the controller in the same edge.
        S_LOAD_B: begin
          if (hs) begin
            w_en_B       <= 1'b1;
            write_addr_B <= cnt;
            write_data_B <= in_data;
            if (cnt == WORD_LAST) begin
              cnt      <= '0;
              in_ready <= 1'b0;
              en       <= 1'b1;
              tmr      <= '0;
              state    <= S_ARM;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end

        // A done left high from the previous job must drop before it can count.
        S_ARM: begin
          if (tmr == TMR_LAST) begin
            timeout <= 1'b1;
            en      <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            tmr <= tmr + TW'(1);
            if (!done) state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (done) begin
            en          <= 1'b0;
            idx         <= '0;
            read_addr_C <= '0;
            lat_cnt     <= '0;
            rd_pend     <= 1'b1;
            state       <= S_DRAIN;
          end else if (tmr == TMR_LAST) begin
            timeout <= 1'b1;
            en      <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end

        // One read in flight at a time; the next address goes out after the consumer takes the word.
        S_DRAIN: begin
          if (rd_pend) begin
            if (lat_cnt == LAT_LAST) begin
              out_data  <= read_data_C;
              out_valid <= 1'b1;
              out_last  <= (idx == RES_LAST);
              rd_pend   <= 1'b0;
            end else begin
              lat_cnt <= lat_cnt + LW'(1);
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              idx         <= idx + CW'(1);
              read_addr_C <= idx + CW'(1);
              lat_cnt     <= '0;
              rd_pend     <= 1'b1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_host_loader.sv
// Directed bench for systolic_host_loader: load sequencing, stale done, drain with
// backpressure, run timeout and mid-load reset.
module tb_systolic_host_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        w_en_A;
  logic [6:0]  write_addr_A;
  logic [15:0] write_data_A;
  logic        w_en_B;
  logic [6:0]  write_addr_B;
  logic [15:0] write_data_B;
  logic        en;
  logic        done;
  logic [4:0]  read_addr_C;
  logic [15:0] read_data_C;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int qh_cyc[$];
  int qa_addr[$], qa_data[$], qa_cyc[$];
  int qb_addr[$], qb_data[$], qb_cyc[$];

  systolic_host_loader #(
    .N_WORDS(16), .N_RESULTS(16), .C_RD_LAT(1), .RUN_TIMEOUT(50)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_en_A(w_en_A), .write_addr_A(write_addr_A), .write_data_A(write_data_A),
    .w_en_B(w_en_B), .write_addr_B(write_addr_B), .write_data_B(write_data_B),
    .en(en), .done(done), .read_addr_C(read_addr_C), .read_data_C(read_data_C),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Memory C: word at address a is 0x0100+a, valid one edge after read_addr_C changes.
  assign read_data_C = 16'h0100 + 16'(read_addr_C);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (in_valid && in_ready) qh_cyc.push_back(cyc);
    if (w_en_A) begin
      qa_addr.push_back(int'(write_addr_A));
      qa_data.push_back(int'(write_data_A));
      qa_cyc.push_back(cyc);
    end
    if (w_en_B) begin
      qb_addr.push_back(int'(write_addr_B));
      qb_data.push_back(int'(write_data_B));
      qb_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_wen"}, 32'({w_en_A, w_en_B}), 32'd0);
    check({tag, "_waddr"}, 32'({write_addr_A, write_addr_B}), 32'd0);
    check({tag, "_wdata"}, {write_data_A, write_data_B}, 32'd0);
    check({tag, "_en"}, 32'(en), 32'd0);
    check({tag, "_raddr"}, 32'(read_addr_C), 32'd0);
    check({tag, "_out"}, 32'({out_valid, out_last, out_data}), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_logs();
    qh_cyc.delete();
    qa_addr.delete(); qa_data.delete(); qa_cyc.delete();
    qb_addr.delete(); qb_data.delete(); qb_cyc.delete();
  endtask

  task automatic load_words(input int n, input logic [15:0] first);
    int k;
    int guard;
    logic acc;
    k = 0;
    guard = 0;
    in_valid = 1'b1;
    in_data = first;
    while (k < n && guard < 400) begin
      acc = in_ready;
      tick();
      guard++;
      if (acc) begin
        k++;
        in_data = first + 16'(k);
      end
    end
    in_valid = 1'b0;
    check("load_count", 32'(k), 32'(n));
  endtask

  initial begin
    int nres;
    int g;
    int n_en;
    logic stalled;
    logic saw_valid;
    logic [15:0] hold_d;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    done = 1'b1; out_ready = 1'b0;

    // Reset then idle
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_quiet", 32'({busy, en, in_ready, w_en_A, w_en_B}), 32'd0);
    end

    // Job 1: load 0x0001..0x0020 with done stale high at ARM entry
    clear_logs();
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_in_ready", 32'(in_ready), 32'd1);
    load_words(32, 16'h0001);
    check("arm_en", 32'(en), 32'd1);
    check("arm_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stale_en", 32'(en), 32'd1);
    end
    done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("wait_en", 32'(en), 32'd1);
    end
    done = 1'b1;
    tick();
    check("done_en_fall", 32'(en), 32'd0);
    check("drain_busy", 32'(busy), 32'd1);

    check("a_pulses", 32'(qa_addr.size()), 32'd16);
    check("b_pulses", 32'(qb_addr.size()), 32'd16);
    check("hs_count", 32'(qh_cyc.size()), 32'd32);
    if (qa_addr.size() == 16 && qb_addr.size() == 16 && qh_cyc.size() == 32) begin
      for (int i = 0; i < 16; i++) begin
        check("a_addr", 32'(qa_addr[i]), 32'(i));
        check("a_data", 32'(qa_data[i]), 32'(i + 1));
        check("a_lat", 32'(qa_cyc[i]), 32'(qh_cyc[i] + 1));
        check("b_addr", 32'(qb_addr[i]), 32'(i));
        check("b_data", 32'(qb_data[i]), 32'(i + 17));
        check("b_lat", 32'(qb_cyc[i]), 32'(qh_cyc[i + 16] + 1));
      end
    end

    // Drain with out_ready toggling
    nres = 0; g = 0; stalled = 1'b0; hold_d = '0;
    while (nres < 16 && g < 300) begin
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(hold_d));
      end
      out_ready = (g % 2 == 0);
      if (out_valid && out_ready) begin
        check("res_data", 32'(out_data), 32'h100 + 32'(nres));
        check("res_last", 32'(out_last), 32'(nres == 15));
        nres++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
        hold_d = out_data;
      end
      tick();
      g++;
    end
    out_ready = 1'b0;
    check("res_count", 32'(nres), 32'd16);
    check("drain_end_busy", 32'(busy), 32'd0);
    check("drain_end_valid", 32'(out_valid), 32'd0);

    // Timeout: done never rises
    done = 1'b0;
    pulse_start();
    load_words(32, 16'h0200);
    n_en = 0; g = 0; saw_valid = 1'b0;
    while (!timeout && g < 200) begin
      if (en) n_en++;
      if (out_valid) saw_valid = 1'b1;
      tick();
      g++;
    end
    check("to_flag", 32'(timeout), 32'd1);
    check("to_en_cycles", 32'(n_en), 32'd50);
    check("to_en", 32'(en), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
    check("to_no_valid", 32'(saw_valid | out_valid), 32'd0);
    tick();
    check("to_sticky", 32'(timeout), 32'd1);
    pulse_start();
    check("to_cleared", 32'(timeout), 32'd0);
    check("to_restart_busy", 32'(busy), 32'd1);

    // Mid-load reset after 5 A words
    clear_logs();
    load_words(5, 16'h00A0);
    check("mid_pulse_addr", 32'(write_addr_A), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("mid_reset");
    check("mid_a_pulses", 32'(qa_addr.size()), 32'd5);
    clear_logs();
    pulse_start();
    load_words(1, 16'h0BEE);
    tick();
    check("restart_pulses", 32'(qa_addr.size()), 32'd1);
    if (qa_addr.size() == 1) begin
      check("restart_addr", 32'(qa_addr[0]), 32'd0);
      check("restart_data", 32'(qa_data[0]), 32'h0BEE);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
